pe_sequencer: RTL and testbench

PE_SEQUENCER -- requirements
Module: pe_sequencer

---
 rtl/pe_pkg.sv | 68 ++++++
 rtl/pe_sequencer_if.sv | 27 ++
 rtl/pe_ctrl_decode.sv | 59 +++++
 rtl/pe_unit.sv | 68 ++++++
 rtl/pe_sequencer.sv | 146 ++++++++++++++
 tb/tb_pe_sequencer.sv | 236 +++++++++++++++++++++++
 6 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE sequencer and the PE datapath it steers:
// opcodes, packed control word, mux encodings, FSM states and result helpers.
package pe_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_MUL  = 2'd1,
        OP_MAC  = 2'd2,
        OP_RELU = 2'd3
    } pe_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_STREAM = 2'd1,
        SEQ_WB     = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic       mux_add_a;
        logic       mux_add_b;
        logic       mux_c_acc;
        logic [1:0] mux_sat8;
        logic       mux_relu;
        logic [1:0] mux_res;
        logic       mux_comb;
        logic       enable_acc;
    } pe_ctrl_t;

    localparam logic       ADD_A_OPA  = 1'b0;
    localparam logic       ADD_A_PROD = 1'b1;
    localparam logic       ADD_B_OPB  = 1'b0;
    localparam logic       ADD_B_ACC  = 1'b1;
    localparam logic       C_ACC_ACC  = 1'b0;
    localparam logic       C_ACC_C    = 1'b1;
    localparam logic [1:0] SAT8_NONE  = 2'd0;
    localparam logic [1:0] SAT8_SUM   = 2'd1;
    localparam logic [1:0] SAT8_PROD  = 2'd2;
    localparam logic       RELU_PROD  = 1'b0;
    localparam logic       RELU_SUM   = 1'b1;
    localparam logic [1:0] RES_PROD   = 2'd0;
    localparam logic [1:0] RES_SUM    = 2'd1;
    localparam logic [1:0] RES_SAT    = 2'd2;
    localparam logic [1:0] RES_RELU   = 2'd3;
    localparam logic       COMB_REG   = 1'b0;
    localparam logic       COMB_LIVE  = 1'b1;

    // A 12-bit two's complement value fits signed 8 bits when bits 11..7 agree.
    function automatic logic [7:0] sat8(input logic [11:0] v);
        logic [7:0] r;
        if (v[11]) begin
            r = (v[10:7] == 4'hF) ? v[7:0] : 8'h80;
        end else begin
            r = (v[10:7] == 4'h0) ? v[7:0] : 8'h7F;
        end
        return r;
    endfunction

    function automatic logic [7:0] relu8(input logic [11:0] v);
        logic [7:0] r;
        if (v[11]) begin
            r = 8'h00;
        end else begin
            r = (v[10:7] == 4'h0) ? v[7:0] : 8'h7F;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_sequencer_if.sv
// Command, operand and result handshakes between a host (master) and the sequencer (slave).
interface pe_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_len;
    logic       cmd_sat;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] op_c;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_last;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_sat, op_valid, op_a, op_b, op_c, res_ready,
        input  cmd_ready, op_ready, res_valid, res_data, res_last
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_sat, op_valid, op_a, op_b, op_c, res_ready,
        output cmd_ready, op_ready, res_valid, res_data, res_last
    );
endinterface

// File: rtl/pe_ctrl_decode.sv
// Pure decode of the PE control word from opcode, saturation flag, beat position and FSM phase.
module pe_ctrl_decode
    import pe_pkg::*;
(
    input  pe_op_e     op,
    input  logic       sat,
    input  logic       first,
    input  logic       last,
    input  seq_state_e phase,
    output pe_ctrl_t   ctrl
);

    // Control word per phase/opcode; anything outside STREAM leaves the PE idle.
    always_comb begin
        ctrl = '0;
        case (phase)
            SEQ_STREAM: begin
                case (op)
                    OP_ADD: begin
                        ctrl.mux_add_a = ADD_A_OPA;
                        ctrl.mux_add_b = ADD_B_OPB;
                        ctrl.mux_sat8  = SAT8_SUM;
                        ctrl.mux_res   = sat ? RES_SAT : RES_SUM;
                        ctrl.mux_comb  = COMB_LIVE;
                    end
                    OP_MUL: begin
                        ctrl.mux_sat8 = SAT8_PROD;
                        ctrl.mux_res  = sat ? RES_SAT : RES_PROD;
                        ctrl.mux_comb = COMB_LIVE;
                    end
                    OP_RELU: begin
                        ctrl.mux_relu = RELU_PROD;
                        ctrl.mux_res  = RES_RELU;
                        ctrl.mux_comb = COMB_LIVE;
                    end
                    OP_MAC: begin
                        ctrl.mux_add_a  = ADD_A_PROD;
                        ctrl.mux_add_b  = ADD_B_ACC;
                        ctrl.mux_c_acc  = first ? C_ACC_C : C_ACC_ACC;
                        ctrl.mux_sat8   = last ? SAT8_SUM : SAT8_NONE;
                        ctrl.mux_res    = (last && sat) ? RES_SAT : RES_SUM;
                        ctrl.mux_comb   = COMB_LIVE;
                        ctrl.enable_acc = 1'b1;
                    end
                    default: begin
                        ctrl = '0;
                    end
                endcase
            end
            SEQ_WB: begin
                ctrl = '0;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/pe_unit.sv
// Processing element: Q4 signed multiply, 12-bit add/accumulate, saturation and ReLU,
// with a registered result that is presented when the live (comb) path is deselected.
module pe_unit
    import pe_pkg::*;
(
    input  logic       clk,
    input  logic       n_reset,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  pe_ctrl_t   ctrl,
    output logic [7:0] r
);

    logic signed [15:0] prod_full_s;
    logic [11:0] prod_s;
    logic [11:0] add_a_s;
    logic [11:0] acc_c_s;
    logic [11:0] add_b_s;
    logic [11:0] sum_s;
    logic [11:0] sat_in_s;
    logic [7:0]  res_s;
    logic [11:0] acc_r;
    logic [7:0]  res_r;

    // Operands are signed Q4, so the product keeps bits 15..4.
    assign prod_full_s = $signed(a) * $signed(b);
    assign prod_s      = prod_full_s[15:4];
    assign add_a_s     = (ctrl.mux_add_a == ADD_A_PROD) ? prod_s : {{4{a[7]}}, a};
    assign acc_c_s     = (ctrl.mux_c_acc == C_ACC_C) ? {{4{c[7]}}, c} : acc_r;
    assign add_b_s     = (ctrl.mux_add_b == ADD_B_ACC) ? acc_c_s : {{4{b[7]}}, b};
    assign sum_s       = add_a_s + add_b_s;

    // Result selection across the saturate, ReLU and raw paths.
    always_comb begin
        sat_in_s = 12'd0;
        res_s    = 8'd0;
        case (ctrl.mux_sat8)
            SAT8_SUM:  sat_in_s = sum_s;
            SAT8_PROD: sat_in_s = prod_s;
            default:   sat_in_s = 12'd0;
        endcase
        case (ctrl.mux_res)
            RES_PROD: res_s = prod_s[7:0];
            RES_SUM:  res_s = sum_s[7:0];
            RES_SAT:  res_s = sat8(sat_in_s);
            RES_RELU: res_s = relu8((ctrl.mux_relu == RELU_SUM) ? sum_s : prod_s);
            default:  res_s = 8'd0;
        endcase
    end

    // Accumulator and held result advance only on enabled beats.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc_r <= 12'd0;
            res_r <= 8'd0;
        end else if (ctrl.enable_acc) begin
            acc_r <= sum_s;
            res_r <= res_s;
        end else begin
            acc_r <= acc_r;
            res_r <= res_r;
        end
    end

    assign r = (ctrl.mux_comb == COMB_LIVE) ? res_s : res_r;

endmodule

// File: rtl/pe_sequencer.sv
// Sequencer: accepts a command, streams operand beats into the PE and returns
// per-element results (ADD/MUL/RELU) or one accumulated result (MAC) via a result register.
module pe_sequencer
    import pe_pkg::*;
(
    input  logic              clk,
    input  logic              n_reset,
    pe_sequencer_if.slave     bus,
    output logic [7:0]        pe_a,
    output logic [7:0]        pe_b,
    output logic [7:0]        pe_c,
    output pe_ctrl_t          pe_ctrl,
    input  logic [7:0]        pe_r,
    output logic              busy
);

    seq_state_e state_r;
    seq_state_e state_nxt_s;
    pe_op_e     op_r;
    logic       sat_r;
    logic [4:0] cnt_r;
    logic       first_r;
    logic       res_valid_r;
    logic [7:0] res_data_r;
    logic       res_last_r;

    logic       is_mac_s;
    logic       last_s;
    logic       res_free_s;
    logic       cmd_fire_s;
    logic       op_ready_s;
    logic       op_fire_s;
    logic       cap_s;
    logic       cap_last_s;
    pe_ctrl_t   dec_ctrl_s;

    assign is_mac_s   = (op_r == OP_MAC);
    assign last_s     = (cnt_r == 5'd1);
    assign res_free_s = !res_valid_r || bus.res_ready;
    assign cmd_fire_s = bus.cmd_valid && (state_r == SEQ_IDLE);
    assign op_fire_s  = bus.op_valid && op_ready_s;

    // Next state, operand readiness and result-capture decisions.
    always_comb begin
        state_nxt_s = state_r;
        op_ready_s  = 1'b0;
        cap_s       = 1'b0;
        cap_last_s  = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                state_nxt_s = cmd_fire_s ? SEQ_STREAM : SEQ_IDLE;
            end
            SEQ_STREAM: begin
                op_ready_s = is_mac_s ? 1'b1 : res_free_s;
                cap_s      = !is_mac_s && bus.op_valid && op_ready_s;
                cap_last_s = last_s;
                if (bus.op_valid && op_ready_s && last_s) begin
                    state_nxt_s = is_mac_s ? SEQ_WB : SEQ_IDLE;
                end else begin
                    state_nxt_s = SEQ_STREAM;
                end
            end
            SEQ_WB: begin
                cap_s       = res_free_s;
                cap_last_s  = 1'b1;
                state_nxt_s = res_free_s ? SEQ_IDLE : SEQ_WB;
            end
            default: begin
                state_nxt_s = SEQ_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= SEQ_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command latch and beat counter; len 0 means sixteen beats.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            op_r    <= OP_ADD;
            sat_r   <= 1'b0;
            cnt_r   <= 5'd0;
            first_r <= 1'b0;
        end else if (cmd_fire_s) begin
            op_r    <= pe_op_e'(bus.cmd_op);
            sat_r   <= bus.cmd_sat;
            cnt_r   <= (bus.cmd_len == 4'd0) ? 5'd16 : {1'b0, bus.cmd_len};
            first_r <= 1'b1;
        end else if (op_fire_s) begin
            cnt_r   <= cnt_r - 5'd1;
            first_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_r;
            first_r <= first_r;
        end
    end

    // Result register: a capture wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            res_valid_r <= 1'b0;
            res_data_r  <= 8'd0;
            res_last_r  <= 1'b0;
        end else if (cap_s) begin
            res_valid_r <= 1'b1;
            res_data_r  <= pe_r;
            res_last_r  <= cap_last_s;
        end else if (bus.res_ready) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    pe_ctrl_decode u_decode (
        .op    (op_r),
        .sat   (sat_r),
        .first (first_r),
        .last  (last_s),
        .phase (state_r),
        .ctrl  (dec_ctrl_s)
    );

    // The accumulator only moves on beats that actually transfer.
    always_comb begin
        pe_ctrl            = dec_ctrl_s;
        pe_ctrl.enable_acc = dec_ctrl_s.enable_acc & op_fire_s;
    end

    assign pe_a          = bus.op_a;
    assign pe_b          = bus.op_b;
    assign pe_c          = bus.op_c;
    assign bus.cmd_ready = (state_r == SEQ_IDLE);
    assign bus.op_ready  = op_ready_s;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_last  = res_last_r;
    assign busy          = (state_r != SEQ_IDLE);

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer driving the real PE; directed cases plus
// randomized commands checked against an arithmetic reference model.
module tb_pe_sequencer;
    import pe_pkg::*;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [7:0] pe_a, pe_b, pe_c, pe_r;
    pe_ctrl_t   pe_ctrl;
    logic       busy;

    pe_sequencer_if bus();

    pe_sequencer dut (
        .clk(clk), .n_reset(n_reset), .bus(bus),
        .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c), .pe_ctrl(pe_ctrl), .pe_r(pe_r), .busy(busy)
    );

    pe_unit u_pe (
        .clk(clk), .n_reset(n_reset), .a(pe_a), .b(pe_b), .c(pe_c), .ctrl(pe_ctrl), .r(pe_r)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic [7:0] got_d[$];
    logic       got_l[$];
    logic signed [7:0] a_arr[16];
    logic signed [7:0] b_arr[16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Result collector plus idle-state invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (n_reset === 1'b1) begin
            if (bus.res_valid && bus.res_ready) begin
                got_d.push_back(bus.res_data);
                got_l.push_back(bus.res_last);
            end
            check("cmd_ready_vs_busy", bus.cmd_ready, !busy);
            if (!busy) check("idle_ctrl_zero", pe_ctrl, 0);
        end
    end

    function automatic logic [7:0] sat_int(input int v);
        return (v > 127) ? 8'h7F : ((v < -128) ? 8'h80 : 8'(v));
    endfunction

    function automatic int wrap12(input int v);
        logic [11:0] t;
        t = 12'(v);
        return int'($signed(t));
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic l);
        exp_d.push_back(d);
        exp_l.push_back(l);
    endtask

    // Reference: products are Q4 (a*b/16, floor); MAC accumulates in 12-bit two's complement.
    task automatic model(input int op, input int n, input bit sat, input logic [7:0] c);
        int p, s, acc;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            p = (int'(a_arr[k]) * int'(b_arr[k])) >>> 4;
            s = int'(a_arr[k]) + int'(b_arr[k]);
            case (op)
                0: push_exp(sat ? sat_int(s) : 8'(s), k == n - 1);
                1: push_exp(sat ? sat_int(p) : 8'(p), k == n - 1);
                3: push_exp((p < 0) ? 8'd0 : ((p > 127) ? 8'd127 : 8'(p)), k == n - 1);
                default: begin
                    acc = wrap12(((k == 0) ? int'($signed(c)) : acc) + p);
                    if (k == n - 1) push_exp(sat ? sat_int(acc) : 8'(acc), 1'b1);
                end
            endcase
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [3:0] len, input logic sat);
        bit ok;
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_len = len;
        bus.cmd_sat = sat;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cmd_ready;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) check("cmd_accept_timeout", ok, 1);
    endtask

    // Drives n beats; on beat stall_at res_ready is held low for five cycles.
    task automatic send_beats(input int n, input logic [7:0] c, input int stall_at, input bit is_elem);
        bit ok;
        logic [7:0] hold_d;
        hold_d = 8'd0;
        for (int k = 0; k < n; k++) begin
            bus.op_valid = 1'b1;
            bus.op_a = a_arr[k];
            bus.op_b = b_arr[k];
            bus.op_c = (k == 0) ? c : 8'($urandom);
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                bus.res_ready = !(k == stall_at && t < 5);
                @(negedge clk);
                if (k == stall_at && t < 5 && is_elem) begin
                    check("stall_op_ready", bus.op_ready, 0);
                    if (t == 0) hold_d = bus.res_data;
                    else check("stall_res_hold", bus.res_data, hold_d);
                end
                ok = bus.op_ready;
                @(posedge clk);
                #1;
            end
            if (!ok) check("beat_accept_timeout", ok, 1);
        end
        bus.op_valid = 1'b0;
        bus.res_ready = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 300 && got_d.size() < exp_d.size(); t++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check({tag, "_data"}, got_d[i], exp_d[i]);
            check({tag, "_last"}, got_l[i], exp_l[i]);
        end
        exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
    endtask

    initial begin
        int op, len, n, stall;
        bit sat;
        logic [7:0] c;
        n_reset = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_len = 4'd0; bus.cmd_sat = 1'b0;
        bus.op_valid = 1'b0; bus.op_a = 8'd0; bus.op_b = 8'd0; bus.op_c = 8'd0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_last", bus.res_last, 0);
        check("rst_op_ready", bus.op_ready, 0);
        check("rst_pe_ctrl", pe_ctrl, 0);
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        // MAC len 2, c=1: 16*32/16 + 16*16/16 + 1 = 49
        a_arr[0] = 8'sd16; b_arr[0] = 8'sd32; a_arr[1] = 8'sd16; b_arr[1] = 8'sd16;
        push_exp(8'h31, 1'b1);
        send_cmd(2'd2, 4'd2, 1'b0); send_beats(2, 8'd1, -1, 1'b0); drain("mac_dir");

        a_arr[0] = 8'sd100; b_arr[0] = 8'sd100;
        push_exp(8'd127, 1'b1);
        send_cmd(2'd0, 4'd1, 1'b1); send_beats(1, 8'd0, -1, 1'b1); drain("add_sat");
        push_exp(8'hC8, 1'b1);
        send_cmd(2'd0, 4'd1, 1'b0); send_beats(1, 8'd0, -1, 1'b1); drain("add_nosat");

        // RELU of Q4 products: -5*16/16, 3*16/16, 100*1/16
        a_arr[0] = -8'sd5; b_arr[0] = 8'sd16; a_arr[1] = 8'sd3; b_arr[1] = 8'sd16;
        a_arr[2] = 8'sd100; b_arr[2] = 8'sd1;
        push_exp(8'd0, 1'b0); push_exp(8'd3, 1'b0); push_exp(8'd6, 1'b1);
        send_cmd(2'd3, 4'd3, 1'b0); send_beats(3, 8'd0, -1, 1'b1); drain("relu_dir");

        for (int k = 0; k < 16; k++) begin a_arr[k] = 8'($urandom); b_arr[k] = 8'($urandom); end
        model(1, 16, 1'b0, 8'd0);
        send_cmd(2'd1, 4'd0, 1'b0); send_beats(16, 8'd0, 6, 1'b1); drain("mul16_stall");

        // Reset while the second MAC beat is offered
        for (int k = 0; k < 4; k++) begin a_arr[k] = 8'sd16; b_arr[k] = 8'sd16; end
        send_cmd(2'd2, 4'd4, 1'b0); send_beats(1, 8'd3, -1, 1'b0);
        bus.op_valid = 1'b1;
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_res_valid", bus.res_valid, 0);
        check("midrst_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        n_reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_result", got_d.size(), 0);
        check("midrst_busy_after", busy, 0);
        a_arr[0] = 8'sd16; b_arr[0] = 8'sd16;
        push_exp(8'd21, 1'b1);
        send_cmd(2'd2, 4'd1, 1'b0); send_beats(1, 8'd5, -1, 1'b0); drain("post_rst_mac");

        // MAC then ADD back to back: the WB result must precede the ADD results
        a_arr[0] = 8'sd16; b_arr[0] = 8'sd16; a_arr[1] = 8'sd32; b_arr[1] = 8'sd16;
        a_arr[2] = 8'sd8;  b_arr[2] = 8'sd32;
        push_exp(8'd64, 1'b1); push_exp(8'd3, 1'b0); push_exp(8'd7, 1'b1);
        send_cmd(2'd2, 4'd3, 1'b0); send_beats(3, 8'd0, -1, 1'b0);
        a_arr[0] = 8'sd1; b_arr[0] = 8'sd2; a_arr[1] = 8'sd3; b_arr[1] = 8'sd4;
        send_cmd(2'd0, 4'd2, 1'b0); send_beats(2, 8'd0, -1, 1'b1); drain("b2b");

        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 3);
            len = $urandom_range(0, 15);
            n = (len == 0) ? 16 : len;
            sat = 1'($urandom_range(0, 1));
            c = 8'($urandom);
            for (int k = 0; k < 16; k++) begin a_arr[k] = 8'($urandom); b_arr[k] = 8'($urandom); end
            stall = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
            model(op, n, sat, c);
            send_cmd(2'(op), 4'(len), sat);
            send_beats(n, c, stall, op != 2);
            drain("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
